// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, reset PC and fetch-queue entry type for the MIPS front end
package mips_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int INST_W      = 32;

    localparam logic [WORD_ADDR_W-1:0] RESET_PC_DEFAULT = 30'h100000;

    // One buffered instruction together with the word address it came from.
    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular instruction queue with push/pop/flush and occupancy count
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   push, entry_in write entry_in at the tail
//   pop            remove the head entry
//   flush          discard all entries (overrides push and pop)
//   head           entry at the head (meaningful only while count != 0)
//   count          number of stored entries, 0..DEPTH
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               entry_in,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage is not reset; the top never looks at head while count is zero.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - instruction fetch stage: credit-limited issue, response queue, redirect flush
//
// Optional feature macro: FETCH_BYPASS_EN (response forwarded to decode in the
// cycle it arrives when the queue is empty).
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   redirect_valid, redirect_pc      taken branch/jr target (word address)
//   imem_req_valid/ready/addr        request channel to instruction memory
//   imem_resp_valid/data             in-order, non-stallable response channel
//   inst_valid/ready, inst, inst_pc  instruction channel to decode
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                     DEPTH    = 4,
    parameter logic [WORD_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [WORD_ADDR_W-1:0] redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [WORD_ADDR_W-1:0] imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INST_W-1:0]      imem_resp_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [INST_W-1:0]      inst,
    output logic [WORD_ADDR_W-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WORD_ADDR_W-1:0] fetch_pc;
    logic [WORD_ADDR_W-1:0] resp_pc;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          drop;
    logic [CW-1:0]          count;
    logic [CW:0]            occupancy;
    logic                   issue;
    logic                   resp_keep;
    logic                   fifo_valid;
    logic                   push;
    logic                   pop;
    fetch_entry_t           head;
    fetch_entry_t           entry_in;

    // Every issued word is guaranteed a queue slot, so the queue cannot overflow.
    assign occupancy      = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid && imem_req_ready;

    // A response is kept only if it is not stale from before a redirect and
    // does not coincide with a new redirect.
    assign resp_keep  = imem_resp_valid && (drop == '0) && !redirect_valid;
    assign fifo_valid = (count != '0);
    assign pop        = fifo_valid && inst_ready && !redirect_valid;
    assign entry_in   = '{pc: resp_pc, inst: imem_resp_data};

`ifdef FETCH_BYPASS_EN
    logic bypass;

    assign bypass     = resp_keep && !fifo_valid;
    assign inst_valid = fifo_valid || bypass;
    assign inst       = fifo_valid ? head.inst : (bypass ? imem_resp_data : '0);
    assign inst_pc    = fifo_valid ? head.pc   : (bypass ? resp_pc        : '0);
    // A bypassed word that decode takes immediately never enters the queue.
    assign push       = resp_keep && !(bypass && inst_ready);
`else
    assign inst_valid = fifo_valid;
    assign inst       = fifo_valid ? head.inst : '0;
    assign inst_pc    = fifo_valid ? head.pc   : '0;
    assign push       = resp_keep;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .entry_in (entry_in),
        .pop      (pop),
        .flush    (redirect_valid),
        .head     (head),
        .count    (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                // Everything still outstanding after this cycle is stale.
                drop     <= inflight - CW'(imem_resp_valid);
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 30'd1;
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + 30'd1;
                end
                if (imem_resp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - directed self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [29:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [29:0] inst_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;

    typedef struct {
        logic [29:0] addr;
        int          due;
    } req_t;
    req_t mq[$];

    always #5 clk = ~clk;

    mips_fetch_unit #(.DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    function automatic logic [31:0] mdata(input logic [29:0] a);
        if (a == 30'h100000) return 32'h2402000A;
        return {2'b01, a} ^ 32'hA5A5_0000;
    endfunction

    // Advance one clock; the memory model answers each request lat cycles later.
    task automatic tick();
        req_t r;
        if (imem_req_valid && imem_req_ready) begin
            r.addr = imem_req_addr;
            r.due  = cyc + lat;
            mq.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdata(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
    endtask

    task automatic do_reset(input int l);
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_req_ready  = 1'b1;
        mq.delete();
        lat = l;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_req_ready  = 1'b1;
        inst_ready      = 1'b1;
        @(posedge clk);
        #2;
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid);
        end
        total++;
        if (inst_valid !== 1'b0) begin
            bad++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid);
        end
        total++;
        if (inst !== 32'h0 || inst_pc !== 30'h0) begin
            bad++; $display("FAIL reset_inst got=%h/%h want=0/0", inst, inst_pc);
        end
    endtask

    task automatic test_stream();
        logic [29:0] e;
        do_reset(1);
        inst_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            e = 30'h100000 + 30'(k);
            total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== e) begin
                bad++; $display("FAIL stream_req k=%0d got=%b/%h want=1/%h", k, imem_req_valid, imem_req_addr, e);
            end
            if (k >= 2 - BYP) begin
                e = 30'h100000 + 30'(k - (2 - BYP));
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== e || inst !== mdata(e)) begin
                    bad++; $display("FAIL stream_inst k=%0d got=%b/%h/%h want=1/%h/%h", k, inst_valid, inst_pc, inst, e, mdata(e));
                end
            end else begin
                total++;
                if (inst_valid !== 1'b0) begin
                    bad++; $display("FAIL stream_fill k=%0d got=%b want=0", k, inst_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          nreq;
        logic [29:0] e;
        inst_ready = 1'b0;
        do_reset(1);
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            if (imem_req_valid && imem_req_ready) nreq++;
            tick();
        end
        total++;
        if (nreq !== 4) begin
            bad++; $display("FAIL bp_req_count got=%0d want=4", nreq);
        end
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL bp_req_stalled got=%b want=0", imem_req_valid);
        end
        inst_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            e = 30'h100000 + 30'(i);
            total++;
            if (inst_valid !== 1'b1 || inst_pc !== e || inst !== mdata(e)) begin
                bad++; $display("FAIL bp_pop i=%0d got=%b/%h want=1/%h", i, inst_valid, inst_pc, e);
            end
            if (i == 0) begin
                total++;
                if (imem_req_valid !== 1'b0) begin
                    bad++; $display("FAIL bp_no_credit got=%b want=0", imem_req_valid);
                end
            end
            if (i == 1) begin
                total++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h100004) begin
                    bad++; $display("FAIL bp_resume got=%b/%h want=1/100004", imem_req_valid, imem_req_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect_drop();
        do_reset(3);
        inst_ready = 1'b1;
        #1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 30'h100040;
        #1;
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL rd_req_blocked got=%b want=0", imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h100040) begin
            bad++; $display("FAIL rd_new_addr got=%b/%h want=1/100040", imem_req_valid, imem_req_addr);
        end
        for (int c = 3; c < 7 - BYP; c++) begin
            total++;
            if (inst_valid !== 1'b0) begin
                bad++; $display("FAIL rd_dropped c=%0d got=%b/%h want=0", c, inst_valid, inst_pc);
            end
            tick();
        end
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 30'h100040 || inst !== mdata(30'h100040)) begin
            bad++; $display("FAIL rd_target got=%b/%h/%h want=1/100040/%h", inst_valid, inst_pc, inst, mdata(30'h100040));
        end
        tick();
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 30'h100041) begin
            bad++; $display("FAIL rd_target_next got=%b/%h want=1/100041", inst_valid, inst_pc);
        end
    endtask

    task automatic test_redirect_collide();
        logic [29:0] e;
        do_reset(1);
        inst_ready = 1'b1;
        #1;
        tick();
        tick();
        e = 30'h100000 + 30'(BYP);
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== e || imem_resp_valid !== 1'b1) begin
            bad++; $display("FAIL rc_setup got=%b/%h/%b want=1/%h/1", inst_valid, inst_pc, imem_resp_valid, e);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 30'h200000;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h200000) begin
            bad++; $display("FAIL rc_req_addr got=%b/%h want=1/200000", imem_req_valid, imem_req_addr);
        end
        total++;
        if (inst_valid !== 1'b0) begin
            bad++; $display("FAIL rc_flushed got=%b/%h want=0", inst_valid, inst_pc);
        end
        tick();
        total++;
        if (inst_valid !== BYP[0] || (BYP == 1 && inst_pc !== 30'h200000)) begin
            bad++; $display("FAIL rc_c4 got=%b/%h want=%0d/200000", inst_valid, inst_pc, BYP);
        end
        tick();
        e = 30'h200000 + 30'(BYP);
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== e) begin
            bad++; $display("FAIL rc_c5 got=%b/%h want=1/%h", inst_valid, inst_pc, e);
        end
    endtask

    task automatic test_wrap();
        int          idx;
        logic [29:0] e;
        do_reset(1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 30'h3FFFFFFF;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        for (int j = 1; j <= 4; j++) begin
            if (j == 1) begin
                total++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h3FFFFFFF) begin
                    bad++; $display("FAIL wrap_req_top got=%b/%h want=1/3fffffff", imem_req_valid, imem_req_addr);
                end
            end
            if (j == 2) begin
                total++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h0) begin
                    bad++; $display("FAIL wrap_req_zero got=%b/%h want=1/0", imem_req_valid, imem_req_addr);
                end
            end
            idx = j - (3 - BYP);
            if (idx == 0 || idx == 1) begin
                e = (idx == 0) ? 30'h3FFFFFFF : 30'h0;
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== e || inst !== mdata(e)) begin
                    bad++; $display("FAIL wrap_inst j=%0d got=%b/%h want=1/%h", j, inst_valid, inst_pc, e);
                end
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        do_reset(1);
        inst_ready = 1'b1;
        #1;
        tick();
        total++;
        if (BYP == 1) begin
            if (inst_valid !== 1'b1 || inst !== 32'h2402000A || inst_pc !== 30'h100000) begin
                bad++; $display("FAIL byp_same_cycle got=%b/%h/%h want=1/2402000a/100000", inst_valid, inst, inst_pc);
            end
        end else begin
            if (inst_valid !== 1'b0) begin
                bad++; $display("FAIL byp_latency got=%b want=0", inst_valid);
            end
        end
        tick();
        total++;
        if (BYP == 1) begin
            if (inst_valid !== 1'b1 || inst_pc !== 30'h100001) begin
                bad++; $display("FAIL byp_no_dup got=%b/%h want=1/100001", inst_valid, inst_pc);
            end
        end else begin
            if (inst_valid !== 1'b1 || inst !== 32'h2402000A || inst_pc !== 30'h100000) begin
                bad++; $display("FAIL byp_queued got=%b/%h/%h want=1/2402000a/100000", inst_valid, inst, inst_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_wrap();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
